// File: rtl/dawson_pkg.sv
// Shared types and constants for the dawson streaming wrapper.
// The state encoding and the legal operand widths live here.
package dawson_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_IDLE,
      ST_TX_A,
      ST_TX_B,
      ST_WAIT_RX
   } dawson_state_t;

   localparam int unsigned WIDTH_NARROW = 32;
   localparam int unsigned WIDTH_WIDE   = 64;

   function automatic bit width_is_legal(input int unsigned w);
      return (w == WIDTH_NARROW) || (w == WIDTH_WIDE);
   endfunction

   function automatic bit depth_is_legal(input int unsigned d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/dawson_req_fifo.sv
// Request FIFO holding {A, B} operand pairs.
// A push is refused while full, even when a pop happens on the same edge.
module dawson_req_fifo #(
   parameter int unsigned DW    = 128,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DW-1:0]          push_data,
   input  logic                   pop,
   output logic [DW-1:0]          pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dawson_stream_if.sv
// Valid/ready streaming front end for a strobe/ack arithmetic unit:
// queues operand pairs, feeds them to the unit and holds one result.
module dawson_stream_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned UNARY = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_a,
   input  logic [WIDTH-1:0]       in_b,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_z,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   clk,
   output logic                   rst,
   output logic [WIDTH-1:0]       input_a,
   output logic [WIDTH-1:0]       input_b,
   output logic                   input_a_stb,
   output logic                   input_b_stb,
   input  logic                   input_a_ack,
   input  logic                   input_b_ack,
   input  logic [WIDTH-1:0]       output_z,
   input  logic                   output_z_stb,
   output logic                   output_z_ack
);

   import dawson_pkg::*;

   if (!width_is_legal(WIDTH) || !depth_is_legal(DEPTH)) begin : g_bad_param
      $error("dawson_stream_if: WIDTH must be 32 or 64, DEPTH a power of two >= 2");
   end

   dawson_state_t      state;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               a_stb;
   logic               b_stb;
   logic [2*WIDTH-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               load_next;

   dawson_req_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_req_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({in_a, in_b}),
      .pop       (load_next),
      .pop_data  (head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign clk          = clock;
   assign rst          = reset | (state == ST_RESET);
   assign in_ready     = ~fifo_full & (state != ST_RESET);
   assign push         = in_valid & in_ready;
   assign busy         = (state != ST_IDLE) | (count != '0);
   assign output_z_ack = (state == ST_WAIT_RX) & output_z_stb & (~out_valid | out_ready);

   // The head is popped either from IDLE or on the edge that retires a result,
   // so a queued request follows a completed one without an idle cycle.
   assign load_next = ~fifo_empty & ((state == ST_IDLE) | output_z_ack);

   assign input_a_stb = a_stb;
   assign input_b_stb = b_stb;
   assign input_a     = a_stb ? op_a : '0;
   assign input_b     = b_stb ? op_b : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_RESET;
         op_a      <= '0;
         op_b      <= '0;
         a_stb     <= 1'b0;
         b_stb     <= 1'b0;
         out_z     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (output_z_ack) begin
            out_z     <= output_z;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (load_next) begin
            op_a  <= head[2*WIDTH-1:WIDTH];
            op_b  <= head[WIDTH-1:0];
            a_stb <= 1'b1;
         end

         case (state)
            ST_RESET: state <= ST_IDLE;
            ST_IDLE: begin
               if (load_next) state <= ST_TX_A;
            end
            ST_TX_A: begin
               if (input_a_ack) begin
                  a_stb <= 1'b0;
                  if (UNARY != 0) begin
                     state <= ST_WAIT_RX;
                  end else begin
                     b_stb <= 1'b1;
                     state <= ST_TX_B;
                  end
               end
            end
            ST_TX_B: begin
               if (input_b_ack) begin
                  b_stb <= 1'b0;
                  state <= ST_WAIT_RX;
               end
            end
            ST_WAIT_RX: begin
               if (output_z_ack) state <= load_next ? ST_TX_A : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
